operand_fetch_unit: RTL and testbench

Parametrised operand-fetch stage that succeeds the fixed 8-bit single-operand decoder. Selects one operand per instruction from the register file, memory, IO, stack pointer or immediate, and applies priority forwarding from N later pipeline stages plus writeback. Tracks in-flight late-result writers (load/IO) with a per-register pending scoreboard, stalls on unresolved hazards, and presents the result through a registered valid/ready output to execute.

---
 rtl/operand_fetch_unit_pkg.sv | 29 ++
 rtl/operand_fwd_mux.sv | 45 ++++
 rtl/operand_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_operand_fetch_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_unit_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// operand_fetch_unit_pkg : source-select encodings and sizing helpers
// Revision 1.0
// ------------------------------------------------------------------
package operand_fetch_unit_pkg;

  localparam logic [2:0] SRC_REG = 3'd0;
  localparam logic [2:0] SRC_MEM = 3'd1;
  localparam logic [2:0] SRC_IO  = 3'd2;
  localparam logic [2:0] SRC_SP  = 3'd3;
  localparam logic [2:0] SRC_IMM = 3'd4;

  localparam int PEND_W_DEFAULT = 2;

  // Minimum index width for a value count; never returns less than 1.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fwd_mux.sv
`default_nettype none
// ------------------------------------------------------------------
// operand_fwd_mux : priority operand select over forwarding ports,
//                   writeback and register-file read data
// Revision 1.0
// ------------------------------------------------------------------
module operand_fwd_mux #(
  parameter int DATA_W     = 8,
  parameter int RIDX_W     = 3,
  parameter int FWD_STAGES = 2
) (
  input  logic [RIDX_W-1:0]            src_reg,
  input  logic [FWD_STAGES-1:0]        fwd_valid,
  input  logic [FWD_STAGES*RIDX_W-1:0] fwd_reg,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  input  logic                         wb_valid,
  input  logic [RIDX_W-1:0]            wb_reg,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic [DATA_W-1:0]            rf_rdata,
  output logic [DATA_W-1:0]            value,
  output logic                         fwd_hit,
  output logic                         wb_hit
);

  logic [FWD_STAGES-1:0] w_match;

  for (genvar i = 0; i < FWD_STAGES; i++) begin : g_match
    assign w_match[i] = fwd_valid[i] & (fwd_reg[i*RIDX_W +: RIDX_W] == src_reg);
  end

  assign fwd_hit = |w_match;
  assign wb_hit  = wb_valid & (wb_reg == src_reg);

  // Walk oldest to youngest so the youngest matching stage wins.
  always_comb begin
    value = wb_hit ? wb_data : rf_rdata;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        value = fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand_fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// operand_fetch_unit : operand select, forwarding, late-writer
//                      scoreboard and registered handoff to execute
// Revision 1.0
// ------------------------------------------------------------------
module operand_fetch_unit
  import operand_fetch_unit_pkg::*;
#(
  parameter int  DATA_W     = 8,
  parameter int  NUM_REGS   = 8,
  parameter int  FWD_STAGES = 2,
  parameter int  PEND_W     = PEND_W_DEFAULT,
  localparam int RIDX_W     = clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_src_sel,
  input  logic [RIDX_W-1:0]            in_src_reg,
  input  logic                         in_dst_wr,
  input  logic [RIDX_W-1:0]            in_dst_reg,
  input  logic                         in_dst_late,
  output logic [RIDX_W-1:0]            rf_raddr,
  input  logic [DATA_W-1:0]            rf_rdata,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic [DATA_W-1:0]            io_data,
  input  logic [DATA_W-1:0]            sp_data,
  input  logic [DATA_W-1:0]            imm_data,
  input  logic [FWD_STAGES-1:0]        fwd_valid,
  input  logic [FWD_STAGES*RIDX_W-1:0] fwd_reg,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  input  logic                         wb_valid,
  input  logic [RIDX_W-1:0]            wb_reg,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic                         wb_late,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_operand,
  output logic                         out_dst_wr,
  output logic [RIDX_W-1:0]            out_dst_reg,
  output logic [15:0]                  stall_count
);

  logic [DATA_W-1:0] w_reg_value;
  logic [DATA_W-1:0] w_operand;
  logic              w_fwd_hit;
  logic              w_wb_hit;
  logic              w_src_is_reg;
  logic              w_raw_d1;
  logic              w_raw_pend;
  logic              w_hazard;
  logic              w_sat_stall;
  logic              w_fire;
  logic [PEND_W-1:0] w_pend [NUM_REGS];

  logic              r_valid;
  logic [DATA_W-1:0] r_operand;
  logic              r_dst_wr;
  logic [RIDX_W-1:0] r_dst_reg;
  logic [15:0]       r_stall;

  assign rf_raddr = in_src_reg;

  operand_fwd_mux #(
    .DATA_W     (DATA_W),
    .RIDX_W     (RIDX_W),
    .FWD_STAGES (FWD_STAGES)
  ) u_fwd_mux (
    .src_reg   (in_src_reg),
    .fwd_valid (fwd_valid),
    .fwd_reg   (fwd_reg),
    .fwd_data  (fwd_data),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .rf_rdata  (rf_rdata),
    .value     (w_reg_value),
    .fwd_hit   (w_fwd_hit),
    .wb_hit    (w_wb_hit)
  );

  // The instruction sitting in the output register has not produced its
  // result yet, so a distance-1 dependency can never be forwarded.
  assign w_src_is_reg = (in_src_sel == SRC_REG);
  assign w_raw_d1     = r_valid & r_dst_wr & (r_dst_reg == in_src_reg);
  assign w_raw_pend   = (w_pend[in_src_reg] != '0) & ~w_fwd_hit & ~w_wb_hit;
  assign w_hazard     = w_src_is_reg & (w_raw_d1 | w_raw_pend);
  assign w_sat_stall  = in_dst_wr & in_dst_late & (&w_pend[in_dst_reg]);

  assign in_ready = ~flush & (~r_valid | out_ready) & ~w_hazard & ~w_sat_stall;
  assign w_fire   = in_valid & in_ready;

  always_comb begin
    case (in_src_sel)
      SRC_REG: w_operand = w_reg_value;
      SRC_MEM: w_operand = mem_data;
      SRC_IO:  w_operand = io_data;
      SRC_SP:  w_operand = sp_data;
      default: w_operand = imm_data;
    endcase
  end

  // One outstanding-late-writer counter per architectural register.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    logic [PEND_W-1:0] r_cnt;
    logic              w_inc;
    logic              w_dec;

    assign w_inc = w_fire & in_dst_wr & in_dst_late & (in_dst_reg == RIDX_W'(r));
    assign w_dec = wb_valid & wb_late & (wb_reg == RIDX_W'(r));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (flush) begin
        r_cnt <= '0;
      end else if (w_inc & ~w_dec) begin
        r_cnt <= r_cnt + PEND_W'(1);
      end else if (w_dec & ~w_inc & (r_cnt != '0)) begin
        r_cnt <= r_cnt - PEND_W'(1);
      end
    end

    assign w_pend[r] = r_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_operand <= '0;
      r_dst_wr  <= 1'b0;
      r_dst_reg <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_valid   <= 1'b1;
      r_operand <= w_operand;
      r_dst_wr  <= in_dst_wr;
      r_dst_reg <= in_dst_reg;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Only dependency stalls are counted; plain backpressure is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (in_valid & ~flush & (w_hazard | w_sat_stall) & (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign out_valid   = r_valid;
  assign out_operand = r_operand;
  assign out_dst_wr  = r_dst_wr;
  assign out_dst_reg = r_dst_reg;
  assign stall_count = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_operand_fetch_unit : directed bench with a behavioural model
// Revision 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_operand_fetch_unit;

  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 8;
  localparam int FWD_STAGES = 2;
  localparam int PEND_W     = 2;
  localparam int RIDX_W     = 3;
  localparam int PEND_MAX   = (1 << PEND_W) - 1;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [2:0]                   in_src_sel;
  logic [RIDX_W-1:0]            in_src_reg;
  logic                         in_dst_wr;
  logic [RIDX_W-1:0]            in_dst_reg;
  logic                         in_dst_late;
  logic [RIDX_W-1:0]            rf_raddr;
  logic [DATA_W-1:0]            rf_rdata;
  logic [DATA_W-1:0]            mem_data;
  logic [DATA_W-1:0]            io_data;
  logic [DATA_W-1:0]            sp_data;
  logic [DATA_W-1:0]            imm_data;
  logic [FWD_STAGES-1:0]        fwd_valid;
  logic [FWD_STAGES*RIDX_W-1:0] fwd_reg;
  logic [FWD_STAGES*DATA_W-1:0] fwd_data;
  logic                         wb_valid;
  logic [RIDX_W-1:0]            wb_reg;
  logic [DATA_W-1:0]            wb_data;
  logic                         wb_late;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_W-1:0]            out_operand;
  logic                         out_dst_wr;
  logic [RIDX_W-1:0]            out_dst_reg;
  logic [15:0]                  stall_count;

  operand_fetch_unit #(
    .DATA_W     (DATA_W),
    .NUM_REGS   (NUM_REGS),
    .FWD_STAGES (FWD_STAGES),
    .PEND_W     (PEND_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_src_sel  (in_src_sel),
    .in_src_reg  (in_src_reg),
    .in_dst_wr   (in_dst_wr),
    .in_dst_reg  (in_dst_reg),
    .in_dst_late (in_dst_late),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .mem_data    (mem_data),
    .io_data     (io_data),
    .sp_data     (sp_data),
    .imm_data    (imm_data),
    .fwd_valid   (fwd_valid),
    .fwd_reg     (fwd_reg),
    .fwd_data    (fwd_data),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .wb_late     (wb_late),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_operand (out_operand),
    .out_dst_wr  (out_dst_wr),
    .out_dst_reg (out_dst_reg),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // Model state: what execute should be holding, and outstanding late writers.
  bit          m_valid;
  logic [7:0]  m_operand;
  bit          m_dst_wr;
  logic [2:0]  m_dst_reg;
  int          m_pend [NUM_REGS];
  int          m_stall;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bypassed();
    bit hit;
    hit = wb_valid && (wb_reg == in_src_reg);
    for (int i = 0; i < FWD_STAGES; i++)
      if (fwd_valid[i] && fwd_reg[i*RIDX_W +: RIDX_W] == in_src_reg) hit = 1;
    return hit;
  endfunction

  function automatic logic [7:0] reg_value();
    for (int i = 0; i < FWD_STAGES; i++)
      if (fwd_valid[i] && fwd_reg[i*RIDX_W +: RIDX_W] == in_src_reg)
        return fwd_data[i*DATA_W +: DATA_W];
    if (wb_valid && wb_reg == in_src_reg) return wb_data;
    return rf_rdata;
  endfunction

  function automatic logic [7:0] source_value();
    case (in_src_sel)
      3'd0:    return reg_value();
      3'd1:    return mem_data;
      3'd2:    return io_data;
      3'd3:    return sp_data;
      default: return imm_data;
    endcase
  endfunction

  function automatic bit blocked();
    bit raw;
    bit sat;
    raw = 0;
    if (in_src_sel == 3'd0)
      raw = (m_valid && m_dst_wr && m_dst_reg == in_src_reg) ||
            (m_pend[in_src_reg] > 0 && !bypassed());
    sat = in_dst_wr && in_dst_late && (m_pend[in_dst_reg] == PEND_MAX);
    return raw || sat;
  endfunction

  function automatic bit exp_ready();
    return !flush && (!m_valid || out_ready) && !blocked();
  endfunction

  task automatic model_reset();
    m_valid = 0; m_operand = 0; m_dst_wr = 0; m_dst_reg = 0; m_stall = 0;
    for (int r = 0; r < NUM_REGS; r++) m_pend[r] = 0;
  endtask

  task automatic model_step();
    bit         fire;
    logic [7:0] v;
    int         delta;
    fire = in_valid && exp_ready();
    v    = source_value();
    if (in_valid && !flush && blocked() && m_stall < 65535) m_stall++;
    for (int r = 0; r < NUM_REGS; r++) begin
      delta = 0;
      if (fire && in_dst_wr && in_dst_late && in_dst_reg == r) delta++;
      if (wb_valid && wb_late && wb_reg == r) delta--;
      m_pend[r] = flush ? 0 : m_pend[r] + delta;
      if (m_pend[r] < 0) m_pend[r] = 0;
      if (m_pend[r] > PEND_MAX) m_pend[r] = PEND_MAX;
    end
    if (flush) m_valid = 0;
    else if (fire) begin
      m_valid = 1; m_operand = v; m_dst_wr = in_dst_wr; m_dst_reg = in_dst_reg;
    end else if (out_ready) m_valid = 0;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, exp_ready());
      chk("rf_raddr", rf_raddr, in_src_reg);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("out_operand", out_operand, m_operand);
        chk("out_dst_wr", out_dst_wr, m_dst_wr);
        chk("out_dst_reg", out_dst_reg, m_dst_reg);
      end
      chk("stall_count", stall_count, m_stall);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_src_sel = 0; in_src_reg = 0; in_dst_wr = 0; in_dst_reg = 0;
    in_dst_late = 0; flush = 0; out_ready = 1; fwd_valid = 0; wb_valid = 0; wb_late = 0;
  endtask

  task automatic instr(input logic [2:0] sel, input logic [2:0] src, input logic dwr,
                       input logic [2:0] dst, input logic late);
    in_valid = 1; in_src_sel = sel; in_src_reg = src;
    in_dst_wr = dwr; in_dst_reg = dst; in_dst_late = late;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_src [8];
    exp_src = '{8'hEE, 8'h44, 8'h55, 8'h66, 8'h77, 8'h77, 8'h77, 8'h77};
    rf_rdata = 0; mem_data = 0; io_data = 0; sp_data = 0; imm_data = 0;
    fwd_reg = 0; fwd_data = 0; wb_reg = 0; wb_data = 0;
    idle();
    model_reset();

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_operand", out_operand, 0);
    chk("rst_out_dst_wr", out_dst_wr, 0);
    chk("rst_out_dst_reg", out_dst_reg, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_in_ready", in_ready, 1);
    tick(); tick();
    rst_n = 1;

    // Plain register read
    rf_rdata = 8'h5A; instr(3'd0, 3'd3, 0, 0, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_operand", out_operand, 8'h5A);
    idle(); tick();

    // Forwarding priority and source select
    fwd_reg = {3'd2, 3'd2}; fwd_data = {8'h22, 8'h11}; fwd_valid = 2'b11;
    rf_rdata = 8'hEE; instr(3'd0, 3'd2, 0, 0, 0);
    tick(); chk("fwd0_wins", out_operand, 8'h11);
    fwd_valid = 2'b10;
    tick(); chk("fwd1_only", out_operand, 8'h22);
    fwd_valid = 2'b00; wb_valid = 1; wb_reg = 3'd2; wb_data = 8'h33;
    tick(); chk("wb_fwd", out_operand, 8'h33);
    fwd_reg = {3'd6, 3'd5}; fwd_valid = 2'b11; wb_reg = 3'd7;
    tick(); chk("rf_fallback", out_operand, 8'hEE);
    fwd_valid = 0; wb_valid = 0;
    mem_data = 8'h44; io_data = 8'h55; sp_data = 8'h66; imm_data = 8'h77;
    for (int s = 0; s < 8; s++) begin
      in_src_sel = 3'(s);
      tick(); chk("src_sel", out_operand, exp_src[s]);
    end
    idle(); tick();

    // Load then dependent use: distance-1 stall, pending stall, wb release
    mem_data = 8'h10; instr(3'd1, 3'd0, 1, 3'd4, 1);
    tick(); chk("load_dst", out_dst_reg, 4);
    instr(3'd0, 3'd4, 0, 0, 0); rf_rdata = 8'h00;
    #2 chk("raw_d1_ready", in_ready, 0);
    tick();
    #2 chk("raw_pend_ready", in_ready, 0);
    tick();
    wb_valid = 1; wb_late = 1; wb_reg = 3'd4; wb_data = 8'h7E;
    #2 chk("wb_release_ready", in_ready, 1);
    tick();
    chk("load_use_operand", out_operand, 8'h7E);
    chk("load_use_stalls", stall_count, 2);
    idle(); tick();

    // Pending saturation on r1
    imm_data = 8'h77; instr(3'd4, 3'd0, 1, 3'd1, 1);
    for (int k = 0; k < 3; k++) tick();
    #2 chk("sat_ready", in_ready, 0);
    tick(); tick();
    wb_valid = 1; wb_late = 1; wb_reg = 3'd1;
    #2 chk("sat_wb_same_cycle", in_ready, 0);
    tick();
    wb_valid = 0; wb_late = 0;
    #2 chk("sat_released", in_ready, 1);
    tick();
    in_valid = 0; wb_valid = 1; wb_late = 1;
    tick();
    in_valid = 1;
    #2 chk("issue_retire_ready", in_ready, 1);
    tick();
    wb_valid = 0; wb_late = 0;
    #2 chk("after_issue_retire", in_ready, 1);
    tick();
    #2 chk("sat_again", in_ready, 0);
    in_valid = 0; wb_valid = 1; wb_late = 1;
    for (int k = 0; k < 4; k++) tick();
    idle(); rf_rdata = 8'h3C; instr(3'd0, 3'd1, 0, 0, 0);
    #2 chk("drained_ready", in_ready, 1);
    tick();
    chk("drained_operand", out_operand, 8'h3C);
    chk("sat_stalls", stall_count, 5);
    idle(); tick();

    // Backpressure
    imm_data = 8'h99; instr(3'd4, 3'd0, 0, 0, 0);
    tick(); chk("bp_first", out_operand, 8'h99);
    imm_data = 8'hAA; out_ready = 0;
    #2 chk("bp_ready", in_ready, 0);
    tick(); chk("bp_hold1", out_operand, 8'h99);
    tick(); chk("bp_hold2", out_operand, 8'h99);
    chk("bp_valid", out_valid, 1);
    chk("bp_stalls", stall_count, 5);
    out_ready = 1;
    #2 chk("bp_release", in_ready, 1);
    tick(); chk("bp_second", out_operand, 8'hAA);
    idle(); tick();

    // Flush with a pending late writer and a valid output
    imm_data = 8'h12; instr(3'd4, 3'd0, 1, 3'd5, 1);
    tick();
    rf_rdata = 8'hC3; instr(3'd0, 3'd5, 0, 0, 0); flush = 1;
    #2 chk("flush_ready", in_ready, 0);
    tick(); chk("flush_valid", out_valid, 0);
    flush = 0;
    #2 chk("post_flush_ready", in_ready, 1);
    tick();
    chk("post_flush_operand", out_operand, 8'hC3);
    chk("flush_stalls", stall_count, 5);
    idle(); tick();

    // Asynchronous reset mid-operation
    imm_data = 8'h5F; instr(3'd4, 3'd0, 1, 3'd2, 1);
    tick(); chk("pre_reset_valid", out_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_operand", out_operand, 0);
    chk("areset_stalls", stall_count, 0);
    model_reset();
    idle(); tick();
    rst_n = 1;
    rf_rdata = 8'h81; instr(3'd0, 3'd2, 0, 0, 0);
    #2 chk("areset_pend_clear", in_ready, 1);
    tick(); chk("areset_operand2", out_operand, 8'h81);
    idle(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
